// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: op codes, funct3 codes, FSM state encoding.
package alu_pkg;

  localparam int ALU_I_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_SRA,
    OP_OR,
    OP_AND,
    OP_BEQ,
    OP_BNEQ,
    OP_BLT,
    OP_BGE,
    OP_BLTU,
    OP_BGEU
  } alu_op_e;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'd0,
    F3_SLL     = 3'd1,
    F3_SLT     = 3'd2,
    F3_SLTU    = 3'd3,
    F3_XOR     = 3'd4,
    F3_SRL_SRA = 3'd5,
    F3_OR      = 3'd6,
    F3_AND     = 3'd7
  } f3_e;

  typedef logic [0:0] state_t;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift engine with start/done handshake: one bit per cycle by default,
// single-cycle barrel shifter when ALU_BARREL_SHIFT_EN is defined.
module alu_shifter
  import alu_pkg::*;
#(
  parameter  int I_WIDTH = ALU_I_WIDTH,
  localparam int SHW     = $clog2(I_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               left,
  input  logic               arith,
  input  logic [I_WIDTH-1:0] data,
  input  logic [SHW-1:0]     shamt,
  output logic               done,
  output logic               busy,
  output logic [I_WIDTH-1:0] res
);

`ifdef ALU_BARREL_SHIFT_EN

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    if (left)       res = data << shamt;
    else if (arith) res = I_WIDTH'($signed(data) >>> shamt);
    else            res = data >> shamt;
  end

  assign done = start;
  assign busy = 1'b0;

`else

  logic [I_WIDTH-1:0] work_q, work_d, step;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               left_q, left_d;
  logic               arith_q, arith_d;

  always_comb begin
    if (left_q) step = {work_q[I_WIDTH-2:0], 1'b0};
    else        step = {arith_q & work_q[I_WIDTH-1], work_q[I_WIDTH-1:1]};

    work_d  = work_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    left_d  = left_q;
    arith_d = arith_q;
    done    = 1'b0;
    res     = data;

    if (busy_q) begin
      work_d = step;
      cnt_d  = cnt_q - SHW'(1);
      res    = step;
      if (cnt_q == SHW'(1)) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end
    end else if (start) begin
      // A zero shift amount is passed straight through in the start cycle.
      if (shamt == '0) begin
        done = 1'b1;
      end else begin
        work_d  = data;
        cnt_d   = shamt;
        busy_d  = 1'b1;
        left_d  = left;
        arith_d = arith;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end

  assign busy = busy_q;

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides and a registered result.
// Define ALU_BARREL_SHIFT_EN to make shifts single-cycle (busy stays low).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter  int I_WIDTH = ALU_I_WIDTH,
  localparam int SHW     = $clog2(I_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [I_WIDTH-1:0] d1In,
  input  logic [I_WIDTH-1:0] d2In,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [I_WIDTH-1:0] result,
  output logic               br_taken,
  output logic               busy
);

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic               br_q, br_d;
  logic [I_WIDTH-1:0] result_q, result_d;
  logic [I_WIDTH-1:0] alu_res, sh_res;
  logic               br_res, lt_s, lt_u;
  logic               accept, is_shift, sh_start, sh_done, sh_busy;
  alu_op_e            op;

  assign op       = alu_op_e'(alu_op);
  assign in_ready = (state_q == ST_IDLE) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign is_shift = is_shift_op(op);
  assign sh_start = accept & is_shift;
  assign lt_s     = $signed(d1In) < $signed(d2In);
  assign lt_u     = d1In < d2In;

  alu_shifter #(.I_WIDTH(I_WIDTH)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (sh_start),
    .left  (op == OP_SLL),
    .arith (op == OP_SRA),
    .data  (d1In),
    .shamt (d2In[SHW-1:0]),
    .done  (sh_done),
    .busy  (sh_busy),
    .res   (sh_res)
  );

  always_comb begin
    alu_res = '0;
    br_res  = 1'b0;
    case (op)
      OP_ADD:  alu_res = d1In + d2In;
      OP_SUB:  alu_res = d1In - d2In;
      OP_SLT:  alu_res = {{(I_WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(I_WIDTH-1){1'b0}}, lt_u};
      OP_XOR:  alu_res = d1In ^ d2In;
      OP_OR:   alu_res = d1In | d2In;
      OP_AND:  alu_res = d1In & d2In;
      OP_BEQ:  br_res  = (d1In == d2In);
      OP_BNEQ: br_res  = (d1In != d2In);
      OP_BLT:  br_res  = lt_s;
      OP_BGE:  br_res  = ~lt_s;
      OP_BLTU: br_res  = lt_u;
      OP_BGEU: br_res  = ~lt_u;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    br_d        = br_q;
    out_valid_d = out_valid_q & ~out_ready;

    if (state_q == ST_SHIFT) begin
      if (sh_done) begin
        result_d    = sh_res;
        br_d        = 1'b0;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
    end else if (accept) begin
      // Shifts that finish in the accept cycle complete like any single-cycle op.
      if (is_shift & ~sh_done) begin
        state_d = ST_SHIFT;
      end else begin
        result_d    = is_shift ? sh_res : alu_res;
        br_d        = br_res;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      br_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      br_q        <= br_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign br_taken  = br_q;
  assign busy      = sh_busy;

endmodule
